// File: rtl/durin_pkg.sv
// Shared datapath constants and the byte-merge helper used by the register
// file write path and the read-port bypass path.
package durin_pkg;

    localparam int WORD_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int BE_W     = WORD_W / 8;

    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: write-to-read bypass, busy masking by a
// same-cycle writeback, and the zero-entry / out-of-range rules.
module rf_read_port
    import durin_pkg::*;
#(
    parameter int WIDTH   = WORD_W,
    parameter int DEPTH   = NUM_REGS,
    parameter int ZERO_R0 = 1,
    parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH-1:0]   word,
    input  logic               busy_bit,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [WIDTH-1:0]   data,
    output logic               busy
);

    logic valid;
    logic hit;

    assign valid = (32'(addr) < DEPTH) && !((ZERO_R0 != 0) && (addr == '0));
    assign hit   = wr_en && (wr_addr == addr);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        data = '0;
        busy = 1'b0;
        if (valid) begin
            data = hit ? WIDTH'(byte_merge(WORD_W'(word), WORD_W'(wr_data), BE_W'(wr_be)))
                       : word;
            busy = busy_bit && !hit;
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with byte-masked writes and a per-entry
// busy scoreboard; issue reserves destinations, writeback releases them.
module register_file
    import durin_pkg::*;
#(
    parameter int WIDTH   = WORD_W,
    parameter int DEPTH   = NUM_REGS,
    parameter int ZERO_R0 = 1,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [AW-1:0]      rd_a_addr,
    input  logic [AW-1:0]      rd_b_addr,
    output logic [WIDTH-1:0]   rd_a_data,
    output logic [WIDTH-1:0]   rd_b_data,
    output logic               rd_a_busy,
    output logic               rd_b_busy,
    input  logic               rsv_en,
    input  logic [AW-1:0]      rsv_addr,
    output logic               rsv_ok
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy_q;

    function automatic logic in_range(input logic [AW-1:0] idx);
        return 32'(idx) < DEPTH;
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] idx);
        return (ZERO_R0 != 0) && (idx == '0);
    endfunction

    function automatic logic [WIDTH-1:0] word_at(input logic [AW-1:0] idx);
        return in_range(idx) ? regs[idx] : '0;
    endfunction

    function automatic logic busy_at(input logic [AW-1:0] idx);
        return in_range(idx) ? busy_q[idx] : 1'b0;
    endfunction

    logic wr_ok;
    logic rsv_free;
    logic rsv_set;

    assign wr_ok    = wr_en && in_range(wr_addr) && !is_zero(wr_addr);
    assign rsv_free = !busy_at(rsv_addr) || (wr_ok && (wr_addr == rsv_addr));
    // Entry 0 accepts reservations as a no-op so issue never stalls on it.
    assign rsv_ok   = rsv_en && in_range(rsv_addr) && (is_zero(rsv_addr) || rsv_free);
    assign rsv_set  = rsv_ok && !is_zero(rsv_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is reset on purpose; consumers rely on every entry reading 0 after reset.
            regs   <= '{default: '0};
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking so the reserve below can override the release in the same cycle.
            if (wr_ok) begin
                regs[wr_addr]   <= WIDTH'(byte_merge(WORD_W'(regs[wr_addr]), WORD_W'(wr_data),
                                                     BE_W'(wr_be)));
                busy_q[wr_addr] <= 1'b0;
            end
            if (rsv_set) busy_q[rsv_addr] <= 1'b1;
        end
    end

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_R0(ZERO_R0), .AW(AW)) u_port_a (
        .addr     (rd_a_addr),
        .word     (word_at(rd_a_addr)),
        .busy_bit (busy_at(rd_a_addr)),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .data     (rd_a_data),
        .busy     (rd_a_busy)
    );

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_R0(ZERO_R0), .AW(AW)) u_port_b (
        .addr     (rd_b_addr),
        .word     (word_at(rd_b_addr)),
        .busy_bit (busy_at(rd_b_addr)),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .data     (rd_b_data),
        .busy     (rd_b_busy)
    );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file (DEPTH=24, ZERO_R0=1): directed scenarios
// followed by a randomized run against a small behavioural model.
module tb_register_file;

    localparam int DEPTH = 24;
    localparam int AW    = 5;

    typedef enum logic [2:0] {S_A_DATA, S_B_DATA, S_A_BUSY, S_B_BUSY, S_RSV_OK} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [63:0] exp;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_be;
    logic [63:0]   wr_data;
    logic [AW-1:0] rd_a_addr, rd_b_addr;
    logic [63:0]   rd_a_data, rd_b_data;
    logic          rd_a_busy, rd_b_busy;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;
    logic          rsv_ok;

    exp_t        sb [$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] m_regs [DEPTH];
    logic        m_busy [DEPTH];

    register_file #(.WIDTH(64), .DEPTH(DEPTH), .ZERO_R0(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .rd_a_addr (rd_a_addr),
        .rd_b_addr (rd_b_addr),
        .rd_a_data (rd_a_data),
        .rd_b_data (rd_b_data),
        .rd_a_busy (rd_a_busy),
        .rd_b_busy (rd_b_busy),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_ok    (rsv_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] observe(input sel_t sel);
        case (sel)
            S_A_DATA: return rd_a_data;
            S_B_DATA: return rd_b_data;
            S_A_BUSY: return 64'(rd_a_busy);
            S_B_BUSY: return 64'(rd_b_busy);
            default:  return 64'(rsv_ok);
        endcase
    endfunction

    task automatic expect_out(input string tag, input sel_t sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        drain();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        wr_be  = 8'h00;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [7:0] be, input logic [63:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_be   = be;
        wr_data = d;
    endtask

    task automatic reserve(input logic [AW-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    // Behavioural reference written straight from the port-level rules.
    function automatic logic m_valid(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && (a != 0);
    endfunction

    function automatic logic [63:0] m_data(input logic [AW-1:0] a);
        logic [63:0] v;
        if (!m_valid(a)) return 64'd0;
        v = m_regs[a];
        if (wr_en && wr_addr == a)
            for (int i = 0; i < 8; i++) if (wr_be[i]) v[i*8 +: 8] = wr_data[i*8 +: 8];
        return v;
    endfunction

    function automatic logic m_busy_out(input logic [AW-1:0] a);
        return m_valid(a) && m_busy[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic logic m_rsv_ok();
        if (!rsv_en || int'(rsv_addr) >= DEPTH) return 1'b0;
        if (rsv_addr == 0) return 1'b1;
        return !m_busy[rsv_addr] || (wr_en && wr_addr == rsv_addr);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'(24 + $urandom_range(0, 7));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        wr_addr = '0; wr_data = '0; rsv_addr = '0;
        rd_a_addr = 5'd5; rd_b_addr = 5'd5;

        expect_out("reset_a_data", S_A_DATA, 64'd0);
        expect_out("reset_a_busy", S_A_BUSY, 64'd0);
        expect_out("reset_rsv_ok", S_RSV_OK, 64'd0);
        sample();
        rst = 1'b1;
        step();

        // Async reset discards data and reservations with no clock edge.
        write(5, 8'hFF, 64'hDEAD_BEEF_0000_0024);
        expect_out("r5_bypass", S_A_DATA, 64'hDEAD_BEEF_0000_0024);
        sample(); step();
        idle(); reserve(5);
        expect_out("r5_array", S_A_DATA, 64'hDEAD_BEEF_0000_0024);
        expect_out("r5_rsv_ok", S_RSV_OK, 64'd1);
        sample(); step();
        idle();
        expect_out("r5_busy", S_A_BUSY, 64'd1);
        sample();
        #2 rst = 1'b0;
        expect_out("async_rst_data", S_A_DATA, 64'd0);
        expect_out("async_rst_busy", S_A_BUSY, 64'd0);
        drain();
        rst = 1'b1;
        step();

        write(3, 8'hFF, 64'h1111_1111_1111_1111);
        step();
        write(3, 8'h0F, 64'h2222_2222_2222_2222);
        rd_a_addr = 3;
        expect_out("be_bypass", S_A_DATA, 64'h1111_1111_2222_2222);
        sample(); step();
        idle();
        rd_b_addr = 3;
        expect_out("be_array", S_A_DATA, 64'h1111_1111_2222_2222);
        expect_out("dual_port_same", S_B_DATA, 64'h1111_1111_2222_2222);
        sample(); step();

        rd_b_addr = 7;
        reserve(7);
        expect_out("r7_rsv1", S_RSV_OK, 64'd1);
        expect_out("r7_not_busy_yet", S_B_BUSY, 64'd0);
        sample(); step();
        expect_out("r7_rsv2_rej", S_RSV_OK, 64'd0);
        expect_out("r7_busy", S_B_BUSY, 64'd1);
        sample(); step();
        idle();
        write(7, 8'hFF, 64'h0123_4567_89AB_CDEF);
        expect_out("r7_release", S_B_BUSY, 64'd0);
        expect_out("r7_wr_bypass", S_B_DATA, 64'h0123_4567_89AB_CDEF);
        sample(); step();
        idle(); reserve(7);
        expect_out("r7_rsv3", S_RSV_OK, 64'd1);
        sample(); step();

        rd_a_addr = 9;
        reserve(9);
        sample(); step();
        write(9, 8'hFF, 64'd24); reserve(9);
        expect_out("r9_wr_rsv_ok", S_RSV_OK, 64'd1);
        expect_out("r9_wr_data", S_A_DATA, 64'd24);
        sample(); step();
        idle();
        expect_out("r9_next_data", S_A_DATA, 64'd24);
        expect_out("r9_next_busy", S_A_BUSY, 64'd1);
        sample(); step();

        rd_a_addr = 0;
        write(0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF); reserve(0);
        expect_out("r0_wr_data", S_A_DATA, 64'd0);
        expect_out("r0_wr_busy", S_A_BUSY, 64'd0);
        expect_out("r0_rsv_ok", S_RSV_OK, 64'd1);
        sample(); step();
        idle();
        expect_out("r0_data", S_A_DATA, 64'd0);
        expect_out("r0_busy", S_A_BUSY, 64'd0);
        sample(); step();

        write(23, 8'hFF, 64'hABCD_0000_1234_5678);
        step();
        write(30, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF); reserve(30);
        rd_a_addr = 30; rd_b_addr = 23;
        expect_out("oor_wr_data", S_A_DATA, 64'd0);
        expect_out("oor_busy", S_A_BUSY, 64'd0);
        expect_out("oor_rsv_ok", S_RSV_OK, 64'd0);
        expect_out("r23_kept_byp", S_B_DATA, 64'hABCD_0000_1234_5678);
        sample(); step();
        idle();
        expect_out("oor_data", S_A_DATA, 64'd0);
        expect_out("r23_kept", S_B_DATA, 64'hABCD_0000_1234_5678);
        sample(); step();

        // Fresh reset so the model starts from a known empty state.
        rst = 1'b0;
        #1 rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = 64'd0;
            m_busy[i] = 1'b0;
        end
        for (int c = 0; c < 200; c++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = rand_addr();
            wr_be     = 8'($urandom());
            wr_data   = {$urandom(), $urandom()};
            rsv_en    = 1'($urandom_range(0, 1));
            rsv_addr  = rand_addr();
            rd_a_addr = rand_addr();
            rd_b_addr = ($urandom_range(0, 3) == 0) ? wr_addr : rand_addr();
            expect_out("rnd_a_data", S_A_DATA, m_data(rd_a_addr));
            expect_out("rnd_b_data", S_B_DATA, m_data(rd_b_addr));
            expect_out("rnd_a_busy", S_A_BUSY, 64'(m_busy_out(rd_a_addr)));
            expect_out("rnd_b_busy", S_B_BUSY, 64'(m_busy_out(rd_b_addr)));
            expect_out("rnd_rsv_ok", S_RSV_OK, 64'(m_rsv_ok()));
            sample();
            if (wr_en && m_valid(wr_addr)) begin
                m_regs[wr_addr] = m_data(wr_addr);
                m_busy[wr_addr] = 1'b0;
            end
            if (m_rsv_ok() && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-ported register file for the durin datapath, replacing banks of discrete 64-bit load registers. It provides two combinational read ports with write-to-read bypass, one byte-masked write port, and a per-entry busy scoreboard. The scoreboard lets issue logic reserve a destination register and lets writeback release it. It sits between decode/issue, which reads and reserves, and writeback, which writes and releases.

## Interface
- WIDTH, 64, data word width in bits; must be a multiple of 8
- DEPTH, 32, number of entries; need not be a power of 2
- ZERO_R0, 1, when 1 entry 0 is hardwired to zero and never busy
- AW (localparam), $clog2(DEPTH), address width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  AW  write index
- wr_be  in  WIDTH/8  byte enables for the write
- wr_data  in  WIDTH  write data
- rd_a_addr, rd_b_addr  in  AW  read indices
- rd_a_data, rd_b_data  out  WIDTH  read data (combinational)
- rd_a_busy, rd_b_busy  out  1  entry has an outstanding reservation
- rsv_en  in  1  request to reserve rsv_addr
- rsv_addr  in  AW  index to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)

## Operation
- Reset (rst low, asynchronous): every entry is cleared to 0 and every busy bit to 0. Outputs then follow combinationally: data 0, busy 0. Reset asserted mid-operation discards all pending writes and reservations immediately.
- **Write:** on a clock edge with wr_en=1, each byte i of entry wr_addr with wr_be[i]=1 takes wr_data byte i. Other bytes retain their value. The write also clears busy[wr_addr], regardless of wr_be.
- **Read:** rd_x_data = array[rd_x_addr], with bypass applied.
- **Bypass:** if wr_en=1 and wr_addr==rd_x_addr, the enabled bytes come from wr_data and the remaining bytes come from the array.
- **Busy output:** rd_x_busy = busy[rd_x_addr] AND NOT (wr_en AND wr_addr==rd_x_addr). A same-cycle writeback both un-busies the entry and supplies the data.
- **Reservation:** rsv_ok = rsv_en AND (entry not busy OR being released by a same-cycle write to rsv_addr). On acceptance, busy[rsv_addr] is 1 after the edge. This holds for a simultaneous write and reserve to the same index: the final busy value is 1 and the data is written.
- **Rejected reservation** (rsv_ok=0): busy state is unchanged. The requester retries; no queueing.
- **ZERO_R0=1, entry 0:**
  - writes are ignored;
  - reads return 0 with no bypass;
  - busy reads 0;
  - rsv_en to entry 0 gives rsv_ok=1 with no state change.
- **Out-of-range index** (≥DEPTH, non-power-of-2 depth):
  - writes are ignored;
  - reads return 0 with busy 0;
  - reservations give rsv_ok=0.
- Two read ports may address the same entry; both see identical values.

## Timing
- Read latency is 0 cycles (combinational from address).
- A written value is visible on the read port in the same cycle via bypass, and from the array from the next cycle.
- Busy is set on the edge following rsv_ok=1 and cleared on the edge of the releasing write.
- rsv_ok and rd_x_busy are combinational from the current-cycle wr_* and rsv_* inputs. There is no combinational path from rsv_* to rd_x_data.
- Throughput is one write, one reservation and two reads per cycle.

## Structure
- Shared package durin_pkg holds:
  - WORD_W = 64;
  - NUM_REGS = 32;
  - the function byte_merge(old, new, be), used by both the write path and the bypass path.
- Sub-module rf_read_port, instantiated twice. It takes the index, array word, busy bit and write-port signals, and produces the bypassed data and the busy output. It applies the ZERO_R0 and out-of-range rules.
- The top level owns the storage array, the busy vector and the reservation logic.

## Test plan
- **Reset:** write 0xDEADBEEF_00000024 to r5, then pulse rst low → rd_a_data=0 and rd_a_busy=0 immediately, before any clock edge.
- **Byte enables and bypass:**
  - r3=0x1111_1111_1111_1111; write wr_be=0x0F, wr_data=0x2222_2222_2222_2222 with rd_a_addr=3 → same cycle reads 0x1111_1111_2222_2222;
  - next cycle, with wr_en=0, still reads 0x1111_1111_2222_2222.
- **Scoreboard:**
  - reserve r7 → rsv_ok=1, and rd_b_busy=1 next cycle;
  - a second reserve of r7 → rsv_ok=0;
  - write r7 → rd_b_busy=0 in the write cycle;
  - next cycle, reserve r7 → rsv_ok=1.
- **Simultaneous write and reserve** to busy r9 with data 24 → rsv_ok=1; the next cycle reads 24 with busy=1.
- **R0 with ZERO_R0=1:** write 0xFF..FF to r0 → reads 0 and busy 0; reserve r0 → rsv_ok=1 and busy stays 0.
- **DEPTH=24:** write and read index 30 → data 0, busy 0, rsv_ok=0; entry 23 is unaffected.
